alu_arbitro_secuenciador: RTL and testbench

Shares the single combinational ALU between two requesters (e.g. instruction-execute unit and address-generation unit) using round-robin arbitration. Accepts one operation per valid/ready handshake and drives the ALU control and operand buses from registered values. Holds them for a programmable settle time, then captures result and status flags and returns a one-cycle completion pulse to the winning requester. Sits between the requesters and the ALU; the ALU is not modified.

---
 rtl/alu_arbitro_secuenciador.sv | 172 +++++++++++++++++
 tb/tb_alu_arbitro_secuenciador.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbitro_secuenciador.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Ports: i_Valido_k/i_Opcode_k/i_Operando_{A,B}_k in, o_Listo_k/o_Hecho_k out,
// o_Control_ALU/o_Operandos to ALU, i_Resultado_ALU/i_Banderas_ALU from ALU,
// o_Resultado/o_Banderas/o_Error captured status, o_Ocupado when not idle.
module alu_arbitro_secuenciador #(
   parameter int unsigned LATENCIA      = 1,
   parameter logic [15:0] OPCODE_VALIDO = 16'hFF04
) (
   input  logic        i_Reloj,
   input  logic        i_Reset_n,
   input  logic        i_Valido_0,
   input  logic        i_Valido_1,
   input  logic [3:0]  i_Opcode_0,
   input  logic [3:0]  i_Opcode_1,
   input  logic [7:0]  i_Operando_A_0,
   input  logic [7:0]  i_Operando_A_1,
   input  logic [7:0]  i_Operando_B_0,
   input  logic [7:0]  i_Operando_B_1,
   output logic        o_Listo_0,
   output logic        o_Listo_1,
   output logic        o_Hecho_0,
   output logic        o_Hecho_1,
   output logic [7:0]  o_Resultado,
   output logic [2:0]  o_Banderas,
   output logic        o_Error,
   output logic        o_Ocupado,
   output logic [3:0]  o_Control_ALU,
   output logic [15:0] o_Operandos,
   input  logic [7:0]  i_Resultado_ALU,
   input  logic [2:0]  i_Banderas_ALU
);

   typedef enum logic [1:0] {
      INACTIVO  = 2'd0,
      EJECUTA   = 2'd1,
      RESPUESTA = 2'd2
   } estado_t;

   localparam logic [3:0] CUENTA_INI = 4'(LATENCIA - 1);

   estado_t     estado_q, estado_d;
   logic        prioridad_q, prioridad_d;
   logic        id_q, id_d;
   logic [3:0]  contador_q, contador_d;
   logic [3:0]  control_q, control_d;
   logic [15:0] operandos_q, operandos_d;
   logic [7:0]  resultado_q, resultado_d;
   logic [2:0]  banderas_q, banderas_d;
   logic        error_q, error_d;
   logic        hecho_0_q, hecho_0_d;
   logic        hecho_1_q, hecho_1_d;

   logic        en_inactivo;
   logic        gana_0;
   logic        gana_1;
   logic        acepta;
   logic [3:0]  opcode_sel;
   logic [7:0]  a_sel;
   logic [7:0]  b_sel;
   logic        legal;

   // Tie goes to the requester named by prioridad.
   assign gana_0 = i_Valido_0 & (~i_Valido_1 | ~prioridad_q);
   assign gana_1 = i_Valido_1 & (~i_Valido_0 | prioridad_q);

   assign en_inactivo = (estado_q == INACTIVO);
   assign acepta      = en_inactivo & (i_Valido_0 | i_Valido_1);

   assign opcode_sel = gana_1 ? i_Opcode_1     : i_Opcode_0;
   assign a_sel      = gana_1 ? i_Operando_A_1 : i_Operando_A_0;
   assign b_sel      = gana_1 ? i_Operando_B_1 : i_Operando_B_0;
   assign legal      = OPCODE_VALIDO[opcode_sel];

   // Listo is masked by reset so every output reads 0 while held in reset.
   assign o_Listo_0 = i_Reset_n & en_inactivo & gana_0;
   assign o_Listo_1 = i_Reset_n & en_inactivo & gana_1;

   assign o_Hecho_0     = hecho_0_q;
   assign o_Hecho_1     = hecho_1_q;
   assign o_Resultado   = resultado_q;
   assign o_Banderas    = banderas_q;
   assign o_Error       = error_q;
   assign o_Ocupado     = ~en_inactivo;
   assign o_Control_ALU = control_q;
   assign o_Operandos   = operandos_q;

   always_comb begin
      estado_d    = estado_q;
      prioridad_d = prioridad_q;
      id_d        = id_q;
      contador_d  = contador_q;
      control_d   = control_q;
      operandos_d = operandos_q;
      resultado_d = resultado_q;
      banderas_d  = banderas_q;
      error_d     = error_q;
      hecho_0_d   = 1'b0;
      hecho_1_d   = 1'b0;
      unique case (estado_q)
         INACTIVO: begin
            if (acepta) begin
               prioridad_d = ~gana_1;
               id_d        = gana_1;
               if (legal) begin
                  estado_d    = EJECUTA;
                  contador_d  = CUENTA_INI;
                  control_d   = opcode_sel;
                  operandos_d = {a_sel, b_sel};
               end else begin
                  // Illegal op never reaches the ALU.
                  estado_d    = RESPUESTA;
                  resultado_d = 8'h00;
                  banderas_d  = 3'b000;
                  error_d     = 1'b1;
                  hecho_0_d   = ~gana_1;
                  hecho_1_d   = gana_1;
               end
            end
         end
         EJECUTA: begin
            if (contador_q == 4'd0) begin
               estado_d    = RESPUESTA;
               resultado_d = i_Resultado_ALU;
               banderas_d  = i_Banderas_ALU;
               error_d     = 1'b0;
               control_d   = 4'h0;
               operandos_d = 16'h0000;
               hecho_0_d   = ~id_q;
               hecho_1_d   = id_q;
            end else begin
               contador_d = contador_q - 4'd1;
            end
         end
         RESPUESTA: begin
            estado_d = INACTIVO;
            error_d  = 1'b0;
         end
         default: begin
            estado_d = INACTIVO;
         end
      endcase
   end

   always_ff @(posedge i_Reloj or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         estado_q    <= INACTIVO;
         prioridad_q <= 1'b0;
         id_q        <= 1'b0;
         contador_q  <= 4'd0;
         control_q   <= 4'h0;
         operandos_q <= 16'h0000;
         resultado_q <= 8'h00;
         banderas_q  <= 3'b000;
         error_q     <= 1'b0;
         hecho_0_q   <= 1'b0;
         hecho_1_q   <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         prioridad_q <= prioridad_d;
         id_q        <= id_d;
         contador_q  <= contador_d;
         control_q   <= control_d;
         operandos_q <= operandos_d;
         resultado_q <= resultado_d;
         banderas_q  <= banderas_d;
         error_q     <= error_d;
         hecho_0_q   <= hecho_0_d;
         hecho_1_q   <= hecho_1_d;
      end
   end

endmodule

// File: tb/tb_alu_arbitro_secuenciador.sv
// Bench for alu_arbitro_secuenciador: two instances (LATENCIA 1 and 3)
// with an XOR ALU stub, checked against a transaction-level model.
module tb_alu_arbitro_secuenciador;

   localparam logic [15:0] OPC_OK = 16'hFF04;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       v0 [2];
   logic       v1 [2];
   logic [3:0] p0 [2];
   logic [3:0] p1 [2];
   logic [7:0] a0 [2];
   logic [7:0] b0 [2];
   logic [7:0] a1 [2];
   logic [7:0] b1 [2];

   logic        l0  [2];
   logic        l1  [2];
   logic        h0  [2];
   logic        h1  [2];
   logic [7:0]  res [2];
   logic [2:0]  flg [2];
   logic        err [2];
   logic        ocu [2];
   logic [3:0]  ctl [2];
   logic [15:0] ops [2];
   logic [7:0]  alu_r [2];
   logic [2:0]  alu_f [2];

   int checks = 0;
   int errors = 0;
   bit mprio [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      assign alu_r[g] = ops[g][15:8] ^ ops[g][7:0];
      assign alu_f[g] = ctl[g][2:0];
      alu_arbitro_secuenciador #(
         .LATENCIA(g == 0 ? 1 : 3),
         .OPCODE_VALIDO(OPC_OK)
      ) u_dut (
         .i_Reloj(clk),
         .i_Reset_n(rst_n),
         .i_Valido_0(v0[g]),
         .i_Valido_1(v1[g]),
         .i_Opcode_0(p0[g]),
         .i_Opcode_1(p1[g]),
         .i_Operando_A_0(a0[g]),
         .i_Operando_A_1(a1[g]),
         .i_Operando_B_0(b0[g]),
         .i_Operando_B_1(b1[g]),
         .o_Listo_0(l0[g]),
         .o_Listo_1(l1[g]),
         .o_Hecho_0(h0[g]),
         .o_Hecho_1(h1[g]),
         .o_Resultado(res[g]),
         .o_Banderas(flg[g]),
         .o_Error(err[g]),
         .o_Ocupado(ocu[g]),
         .o_Control_ALU(ctl[g]),
         .o_Operandos(ops[g]),
         .i_Resultado_ALU(alu_r[g]),
         .i_Banderas_ALU(alu_f[g])
      );
   end

   function automatic int lat(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   // All outputs packed: {l0,l1,h0,h1,res,flg,err,ocu,ctl,ops}
   function automatic logic [36:0] outs(input int d);
      return {l0[d], l1[d], h0[d], h1[d], res[d], flg[d],
              err[d], ocu[d], ctl[d], ops[d]};
   endfunction

   // Called just after a negedge with DUT d idle; returns one negedge
   // after the completion cycle, DUT idle again.
   task automatic do_op(input int d, input bit va, input bit vb,
                        input logic [3:0] q0, input logic [7:0] x0,
                        input logic [7:0] y0, input logic [3:0] q1,
                        input logic [7:0] x1, input logic [7:0] y1,
                        input bit keep);
      bit w;
      bit legal;
      logic [3:0] op;
      logic [7:0] a, b, er;
      logic [2:0] ef;
      logic [25:0] got, exp;
      v0[d] = va; v1[d] = vb;
      p0[d] = q0; a0[d] = x0; b0[d] = y0;
      p1[d] = q1; a1[d] = x1; b1[d] = y1;
      #1;
      w = (va && vb) ? mprio[d] : !va;
      checks++;
      if ({l0[d], l1[d]} !== (w ? 2'b01 : 2'b10)) begin
         errors++;
         $display("FAIL listo d=%0d got=%b exp=%b", d, {l0[d], l1[d]},
                  (w ? 2'b01 : 2'b10));
      end
      op = w ? q1 : q0;
      a  = w ? x1 : x0;
      b  = w ? y1 : y0;
      legal = OPC_OK[op];
      mprio[d] = !w;
      er = legal ? (a ^ b) : 8'h00;
      ef = legal ? op[2:0] : 3'b000;
      @(posedge clk);
      @(negedge clk);
      if (legal) begin
         for (int i = 0; i < lat(d); i++) begin
            got = {ctl[d], ops[d], h0[d], h1[d], l0[d], l1[d],
                   ocu[d], 1'b0};
            exp = {op, a, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL exec d=%0d cyc=%0d got=%h exp=%h",
                        d, i, got, exp);
            end
            @(negedge clk);
         end
      end
      got = {ctl[d], ops[d], h0[d], h1[d], 2'b00, ocu[d], err[d]};
      exp = {4'h0, 16'h0000, !w, w, 2'b00, 1'b1, !legal};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL resp d=%0d got=%h exp=%h", d, got, exp);
      end
      checks++;
      if ({res[d], flg[d]} !== {er, ef}) begin
         errors++;
         $display("FAIL result d=%0d op=%h got=%h/%b exp=%h/%b",
                  d, op, res[d], flg[d], er, ef);
      end
      @(negedge clk);
      checks++;
      if ({h0[d], h1[d], err[d], ocu[d], res[d], flg[d]} !==
          {4'b0000, er, ef}) begin
         errors++;
         $display("FAIL after d=%0d got=%b%b%b%b/%h exp=0000/%h",
                  d, h0[d], h1[d], err[d], ocu[d], res[d], er);
      end
      if (!keep) begin
         v0[d] = 1'b0;
         v1[d] = 1'b0;
      end
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         v0[d] = 1'b0; v1[d] = 1'b0;
         p0[d] = 4'h0; p1[d] = 4'h0;
         a0[d] = 8'h00; b0[d] = 8'h00; a1[d] = 8'h00; b1[d] = 8'h00;
         mprio[d] = 1'b0;
      end
      v0[0] = 1'b1;
      p0[0] = 4'h8; a0[0] = 8'h7F; b0[0] = 8'h01;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (outs(d) !== 37'd0) begin
            errors++;
            $display("FAIL reset_outs d=%0d got=%h exp=0", d, outs(d));
         end
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (l0[0] !== 1'b1) begin
         errors++;
         $display("FAIL reset_listo got=%b exp=1", l0[0]);
      end
   endtask

   task automatic test_single();
      do_op(0, 1, 0, 4'h8, 8'h7F, 8'h01, 4'h0, 8'h00, 8'h00, 0);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 4; n++)
         do_op(0, 1, 1, 4'h9, 8'hEE, 8'hF7, 4'hA, 8'h05, 8'h03, n != 3);
   endtask

   task automatic test_illegal();
      do_op(0, 0, 1, 4'h0, 8'h00, 8'h00, 4'h5, 8'h33, 8'h44, 0);
      do_op(1, 1, 0, 4'h3, 8'h12, 8'h34, 4'h0, 8'h00, 8'h00, 0);
   endtask

   task automatic test_lat3();
      do_op(1, 1, 0, 4'hF, 8'h05, 8'h02, 4'h0, 8'h00, 8'h00, 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         int d;
         bit va, vb;
         d  = int'($urandom_range(0, 1));
         va = bit'($urandom_range(0, 1));
         vb = va ? bit'($urandom_range(0, 1)) : 1'b1;
         do_op(d, va, vb,
               4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
               4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
               0);
      end
   endtask

   task automatic test_reset_mid();
      v0[1] = 1'b1; v1[1] = 1'b1;
      p0[1] = 4'h8; a0[1] = 8'h11; b0[1] = 8'h22;
      p1[1] = 4'h9; a1[1] = 8'h33; b1[1] = 8'h44;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ocu[1] !== 1'b1 || ctl[1] === 4'h0) begin
         errors++;
         $display("FAIL mid_busy got=%b/%h exp=1/nonzero", ocu[1], ctl[1]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (outs(1) !== 37'd0) begin
         errors++;
         $display("FAIL mid_clear got=%h exp=0", outs(1));
      end
      repeat (4) begin
         @(negedge clk);
         checks++;
         if ({h0[1], h1[1]} !== 2'b00) begin
            errors++;
            $display("FAIL mid_hecho got=%b exp=00", {h0[1], h1[1]});
         end
      end
      rst_n = 1'b1;
      mprio[0] = 1'b0;
      mprio[1] = 1'b0;
      do_op(1, 1, 1, 4'hC, 8'hA5, 8'h5A, 4'hD, 8'h01, 8'h02, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_illegal();
      test_lat3();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
